zigzag_rle: RTL and testbench

- Consumes quantized coefficients in zigzag scan order, one 8x8 block (64 coefficients) at a time.
- Sits directly downstream of the zigzag scan stage.
- Emits JPEG-style run-length symbols: (run, size, amplitude), ZRL and EOB.
- Its output feeds the Huffman/entropy packing stage.
- Valid/ready handshake on both sides; single registered output slot.

---
 rtl/zigzag_rle.sv | 119 +++++++++++
 tb/tb_zigzag_rle.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle.sv
// zigzag_rle: turns zigzag-ordered quantized coefficients into JPEG run-length symbols
// (DC, run/size/amplitude, ZRL, EOB) behind a single registered output slot.
module zigzag_rle #(
  parameter int COEF_W   = 12,
  parameter int BLK_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic signed [COEF_W-1:0] coef,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     sym_dc,
  output logic [3:0]               sym_run,
  output logic [3:0]               sym_size,
  output logic [COEF_W-1:0]        sym_amp,
  output logic                     sym_last
);
  localparam int IW = $clog2(BLK_SIZE);
  localparam int SW = COEF_W + 10;
  localparam int LW = COEF_W + 5;
  localparam logic [SW-1:0] ZRL_SYM = {1'b0, 4'd15, 4'd0, {COEF_W{1'b0}}, 1'b0};
  localparam logic [SW-1:0] EOB_SYM = {1'b0, 4'd0, 4'd0, {COEF_W{1'b0}}, 1'b1};

  typedef enum logic {ACCEPT, ZRL} state_t;

  state_t            r_state, w_state_n;
  logic              r_live;
  logic [IW-1:0]     r_idx, w_idx_n;
  logic [5:0]        r_run, w_run_n;
  logic [LW-1:0]     r_lat, w_lat_n;
  logic              r_valid, w_valid_n;
  logic [SW-1:0]     r_sym, w_sym_n;
  logic [COEF_W-1:0] w_mag, w_vm1, w_amp;
  logic [3:0]        w_size;
  logic              w_slot, w_xfer, w_end, w_zero;

  assign w_slot     = !r_valid || sym_ready;
  assign coef_ready = r_live && (r_state == ACCEPT) && w_slot;
  assign w_xfer     = coef_valid && coef_ready;
  assign w_end      = r_idx == IW'(BLK_SIZE - 1);
  assign w_zero     = coef == '0;
  assign w_mag      = coef[COEF_W-1] ? COEF_W'(-coef) : COEF_W'(coef);
  assign w_vm1      = COEF_W'(coef) - 1'b1;
  assign sym_valid  = r_valid;
  assign {sym_dc, sym_run, sym_size, sym_amp, sym_last} = r_sym;

  // Negative amplitudes are the low size bits of v-1 (one's complement of |v|).
  always_comb begin
    w_size = '0;
    w_amp  = '0;
    for (int b = 0; b < COEF_W; b++) if (w_mag[b]) w_size = 4'(b + 1);
    for (int b = 0; b < COEF_W; b++)
      w_amp[b] = (4'(b) < w_size) && (coef[COEF_W-1] ? w_vm1[b] : coef[b]);
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_run_n   = r_run;
    w_lat_n   = r_lat;
    w_valid_n = r_valid && !sym_ready;
    w_sym_n   = r_sym;
    if (w_xfer) begin
      w_idx_n = w_end ? '0 : r_idx + 1'b1;
      w_run_n = '0;
      if (r_idx == '0) begin
        w_valid_n = 1'b1;
        w_sym_n   = {1'b1, 4'd0, w_size, w_amp, 1'b0};
      end else if (w_zero && !w_end) begin
        w_run_n = r_run + 1'b1;
      end else if (w_zero) begin
        w_valid_n = 1'b1;
        w_sym_n   = EOB_SYM;
      end else if (r_run < 6'd16) begin
        w_valid_n = 1'b1;
        w_sym_n   = {1'b0, r_run[3:0], w_size, w_amp, w_end};
      end else begin
        // First ZRL goes out with the transfer itself to keep the slot busy every cycle.
        w_valid_n = 1'b1;
        w_sym_n   = ZRL_SYM;
        w_run_n   = r_run - 6'd16;
        w_lat_n   = {w_size, w_amp, w_end};
        w_state_n = ZRL;
      end
    end else if (r_state == ZRL && w_slot) begin
      w_valid_n = 1'b1;
      if (r_run >= 6'd16) begin
        w_sym_n = ZRL_SYM;
        w_run_n = r_run - 6'd16;
      end else begin
        w_sym_n   = {1'b0, r_run[3:0], r_lat};
        w_run_n   = '0;
        w_state_n = ACCEPT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCEPT;
      r_live  <= 1'b0;
      r_idx   <= '0;
      r_run   <= '0;
      r_lat   <= '0;
      r_valid <= 1'b0;
      r_sym   <= '0;
    end else begin
      r_state <= w_state_n;
      r_live  <= 1'b1;
      r_idx   <= w_idx_n;
      r_run   <= w_run_n;
      r_lat   <= w_lat_n;
      r_valid <= w_valid_n;
      r_sym   <= w_sym_n;
    end
  end
endmodule

// File: tb/tb_zigzag_rle.sv
// tb_zigzag_rle: directed and random blocks against a queue-based run-length reference model.
module tb_zigzag_rle;
  localparam int W = 12;
  typedef logic [21:0] sym_t;

  logic                clk = 1'b0, rst_n = 1'b0, coef_valid = 1'b0, sym_ready = 1'b0;
  logic signed [W-1:0] coef = '0;
  logic                coef_ready, sym_valid, sym_dc, sym_last;
  logic [3:0]          sym_run, sym_size;
  logic [W-1:0]        sym_amp;
  sym_t                obs;

  int   checks = 0, errors = 0, st = 0;
  int   blk[64];
  int   coef_q[$];
  sym_t exp_q[$];

  zigzag_rle #(.COEF_W(W), .BLK_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .coef_valid(coef_valid), .coef_ready(coef_ready), .coef(coef),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_dc(sym_dc), .sym_run(sym_run),
    .sym_size(sym_size), .sym_amp(sym_amp), .sym_last(sym_last)
  );

  assign obs = {sym_dc, sym_run, sym_size, sym_amp, sym_last};
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sz(input int v);
    int m = v < 0 ? -v : v;
    int s = 0;
    while (m > 0) begin
      s++;
      m = m >> 1;
    end
    return s;
  endfunction

  function automatic int ap(input int v);
    return v > 0 ? v : (v < 0 ? v - 1 + (1 << sz(v)) : 0);
  endfunction

  function automatic sym_t mk(input bit dc, input int run, input int v, input bit last);
    return {dc, 4'(run), 4'(sz(v)), 12'(ap(v)), last};
  endfunction

  task automatic add_block(input int b[64]);
    int run = 0;
    for (int i = 0; i < 64; i++) begin
      coef_q.push_back(b[i]);
      if (i == 0) exp_q.push_back(mk(1, 0, b[i], 0));
      else if (b[i] == 0 && i == 63) exp_q.push_back(mk(0, 0, 0, 1));
      else if (b[i] == 0) run++;
      else begin
        while (run >= 16) begin
          exp_q.push_back(mk(0, 15, 0, 0));
          run -= 16;
        end
        exp_q.push_back(mk(0, run, b[i], i == 63));
        run = 0;
      end
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic run_stream(input int p_ready, input int p_valid, output int stalls);
    int          k = 0, cyc = 0;
    bit          held = 0;
    logic [22:0] prev = '0;
    stalls = 0;
    while ((k < coef_q.size() || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      sym_ready  = $urandom_range(99) < p_ready;
      coef_valid = k < coef_q.size() && $urandom_range(99) < p_valid;
      coef       = coef_valid ? W'(coef_q[k]) : '0;
      #1;
      if (held) check("hold", {sym_valid, obs}, prev);
      if (sym_valid && sym_ready) begin
        if (exp_q.size() > 0) check("sym", obs, exp_q.pop_front());
        else check("extra_sym", obs, 32'hffffffff);
      end
      if (coef_valid && coef_ready) k++;
      else if (coef_valid) stalls++;
      held = sym_valid && !sym_ready;
      prev = {sym_valid, obs};
    end
    @(posedge clk);
    #1;
    coef_valid = 1'b0;
    coef       = '0;
    check("drain_sym", exp_q.size(), 0);
    check("drain_coef", coef_q.size() - k, 0);
    coef_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2;
    check("rst_valid", sym_valid, 0);
    check("rst_sym", obs, 0);
    check("rst_ready", coef_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("ready_up", coef_ready, 1);

    clear_blk();
    add_block(blk);
    run_stream(100, 100, st);
    check("zero_stall", st, 0);

    clear_blk();
    blk[0] = -3;
    blk[1] = 5;
    add_block(blk);
    run_stream(100, 100, st);

    clear_blk();
    blk[40] = 1;
    add_block(blk);
    run_stream(100, 100, st);
    check("zrl_stall", st, 2);

    clear_blk();
    blk[63] = -1;
    add_block(blk);
    clear_blk();
    blk[0] = 5;
    blk[1] = -1;
    add_block(blk);
    run_stream(100, 100, st);

    clear_blk();
    blk[0] = -2048;
    blk[1] = 2047;
    blk[2] = -2047;
    add_block(blk);
    run_stream(100, 100, st);

    for (int b = 0; b < 20; b++) begin
      int dens = (b % 3 == 0) ? 3 : ((b % 3 == 1) ? 15 : 50);
      for (int i = 0; i < 64; i++) begin
        int v = int'($urandom_range(4095)) - 2048;
        blk[i] = ($urandom_range(99) < dens) ? (v == 0 ? 1 : v) : 0;
      end
      add_block(blk);
    end
    run_stream(50, 80, st);

    clear_blk();
    blk[0] = 7;
    blk[29] = 100;
    sym_ready = 1'b1;
    begin
      int k = 0, cyc = 0;
      while (k < 30 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        coef_valid = 1'b1;
        coef = W'(blk[k]);
        #1;
        if (coef_ready) k++;
      end
      check("pre_rst_fed", k, 30);
    end
    @(negedge clk);
    coef_valid = 1'b0;
    sym_ready  = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_zrl", {sym_valid, obs}, {1'b1, mk(0, 15, 0, 0)});
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", sym_valid, 0);
    check("mid_rst_sym", obs, 0);
    check("mid_rst_ready", coef_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = ($urandom_range(99) < 20) ? int'($urandom_range(200)) - 100 : 0;
    blk[0] = -9;
    add_block(blk);
    run_stream(70, 90, st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
